// File: rtl/shared_fu_arbiter_if.sv
// Requester-side and FU-side signals of the shared functional-unit arbiter.
// Operand buses carry one DATA_W slice per requester, with slice i belonging to requester i.
interface shared_fu_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_opa;
  logic [NUM_REQ*DATA_W-1:0] req_opb;
  logic [NUM_REQ-1:0]        stall;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      fu_issue;
  logic [DATA_W-1:0]         fu_opa;
  logic [DATA_W-1:0]         fu_opb;
  logic [DATA_W-1:0]         fu_result;

  modport slave (
    input  req, req_opa, req_opb, fu_result,
    output stall, rsp_valid, rsp_data, fu_issue, fu_opa, fu_opb
  );

  modport master (
    output req, req_opa, req_opb, fu_result,
    input  stall, rsp_valid, rsp_data, fu_issue, fu_opa, fu_opb
  );
endinterface

// File: rtl/shared_fu_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined FU. Issue is combinational and the result returns after LAT cycles.
// A requester stays stalled from its request until its own rsp_valid cycle. The tag pipe never stalls.
module shared_fu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int LAT     = 3
) (
  input  logic               clk,
  input  logic               reset,
  shared_fu_arbiter_if.slave io_fu
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] r_pending;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [LAT-1:0]     r_tag_vld;
  logic [IDX_W-1:0]   r_tag_idx [LAT];
  logic               r_rst_q;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_rsp;
  logic [NUM_REQ-1:0] w_issue_oh;
  logic [IDX_W-1:0]   w_winner;
  logic               w_found;
  logic               w_issue;

  assign w_elig = io_fu.req & ~r_pending;

  always_comb begin
    int j;
    w_found  = 1'b0;
    w_winner = '0;
    j        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(r_rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!w_found && w_elig[IDX_W'(j)]) begin
        w_found  = 1'b1;
        w_winner = IDX_W'(j);
      end
    end
  end

  // Issue is held off in the reset cycle and the one after it.
  assign w_issue    = w_found & ~reset & ~r_rst_q;
  assign w_issue_oh = w_issue ? (NUM_REQ'(1) << w_winner) : '0;
  assign w_rsp      = (r_tag_vld[LAT-1] && !reset) ? (NUM_REQ'(1) << r_tag_idx[LAT-1]) : '0;

  assign io_fu.fu_issue  = w_issue;
  assign io_fu.fu_opa    = io_fu.req_opa[int'(w_winner)*DATA_W +: DATA_W];
  assign io_fu.fu_opb    = io_fu.req_opb[int'(w_winner)*DATA_W +: DATA_W];
  assign io_fu.rsp_valid = w_rsp;
  assign io_fu.rsp_data  = io_fu.fu_result;
  assign io_fu.stall     = io_fu.req & ~w_rsp;

  always_ff @(posedge clk) begin
    r_rst_q <= reset;
    if (reset) begin
      r_pending <= '0;
      r_rr_ptr  <= '0;
      r_tag_vld <= '0;
    end else begin
      // Issue and response never target the same requester in one cycle.
      r_pending    <= (r_pending & ~w_rsp) | w_issue_oh;
      r_tag_vld[0] <= w_issue;
      for (int k = 1; k < LAT; k++) r_tag_vld[k] <= r_tag_vld[k-1];
      if (w_issue)
        r_rr_ptr <= (w_winner == IDX_W'(NUM_REQ-1)) ? '0 : w_winner + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    r_tag_idx[0] <= w_winner;
    for (int k = 1; k < LAT; k++) r_tag_idx[k] <= r_tag_idx[k-1];
  end
endmodule
